// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared types and widths for the seven-segment scan controller.
// Also holds the leading-zero blanking rule so other display blocks can reuse it.
package sseg_scan_ctrl_pkg;

    localparam int DIGIT_IDX_W = 2;
    localparam int NIBBLE_W    = 4;
    localparam int NUM_DIGITS  = 4;
    localparam int DATA_W      = NUM_DIGITS * NIBBLE_W;

    typedef enum logic {
        EMPTY,
        PENDING
    } load_state_e;

    // A digit is blanked when it and every digit to its left carry a zero
    // nibble and no decimal point; the rightmost digit is always shown.
    function automatic logic leading_zero_blank(
        input logic [DATA_W-1:0]      data,
        input logic [NUM_DIGITS-1:0]  dp,
        input logic [DIGIT_IDX_W-1:0] idx
    );
        logic blank;
        blank = (idx != '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx)) begin
                if ((data[k*NIBBLE_W +: NIBBLE_W] != '0) || dp[k]) begin
                    blank = 1'b0;
                end
            end
        end
        return blank;
    endfunction

endpackage

// File: rtl/sseg_scan_ctrl_refresh_prescaler.sv
// Free-running divider that marks the last clock cycle of every digit slot.
// Counts 0..DIV-1 and wraps; slot_end is high while the count sits at DIV-1.
module refresh_prescaler #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic reset_n,
    output logic slot_end
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: advance by one, folding back to zero after the last slot cycle.
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST) begin
            count_d = '0;
        end
    end

    // Counter register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign slot_end = (count_q == LAST);

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed display scan controller.
// New digits are staged in a pending register and only committed to the
// displayed (active) register at a frame boundary, so a frame never shows a
// mix of old and new digits. All digit outputs come from registers only.
module sseg_scan_ctrl
    import sseg_scan_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DATA_W-1:0]      data_in,
    input  logic [NUM_DIGITS-1:0]  dp_in,
    input  logic                   load_valid,
    output logic                   load_ready,
    output logic [DIGIT_IDX_W-1:0] refreshcounter,
    output logic [NIBBLE_W-1:0]    digit_nibble,
    output logic                   digit_dp,
    output logic                   digit_blank,
    output logic                   frame_tick
);

    localparam logic [DIGIT_IDX_W-1:0] LAST_DIGIT = DIGIT_IDX_W'(NUM_DIGITS - 1);

    logic slot_end;
    logic frame_boundary;

    logic [DIGIT_IDX_W-1:0] refresh_q, refresh_d;
    logic                   frame_tick_q;
    load_state_e            state_q, state_d;
    logic [DATA_W-1:0]      pending_data_q, pending_data_d;
    logic [NUM_DIGITS-1:0]  pending_dp_q, pending_dp_d;
    logic [DATA_W-1:0]      active_data_q, active_data_d;
    logic [NUM_DIGITS-1:0]  active_dp_q, active_dp_d;

    refresh_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .slot_end (slot_end)
    );

    assign frame_boundary = slot_end && (refresh_q == LAST_DIGIT);

    // Digit index steps once per slot and wraps naturally from 3 to 0.
    always_comb begin
        refresh_d = refresh_q;
        if (slot_end) begin
            refresh_d = refresh_q + DIGIT_IDX_W'(1);
        end
    end

    // Load handshake: accept one update when empty, hold it until the frame
    // boundary, then publish it to the active register and reopen.
    always_comb begin
        state_d        = state_q;
        pending_data_d = pending_data_q;
        pending_dp_d   = pending_dp_q;
        active_data_d  = active_data_q;
        active_dp_d    = active_dp_q;
        case (state_q)
            EMPTY: begin
                if (load_valid) begin
                    pending_data_d = data_in;
                    pending_dp_d   = dp_in;
                    state_d        = PENDING;
                end
            end
            PENDING: begin
                if (frame_boundary) begin
                    active_data_d = pending_data_q;
                    active_dp_d   = pending_dp_q;
                    state_d       = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // All controller state, cleared together by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            refresh_q      <= '0;
            frame_tick_q   <= 1'b0;
            state_q        <= EMPTY;
            pending_data_q <= '0;
            pending_dp_q   <= '0;
            active_data_q  <= '0;
            active_dp_q    <= '0;
        end else begin
            refresh_q      <= refresh_d;
            frame_tick_q   <= frame_boundary;
            state_q        <= state_d;
            pending_data_q <= pending_data_d;
            pending_dp_q   <= pending_dp_d;
            active_data_q  <= active_data_d;
            active_dp_q    <= active_dp_d;
        end
    end

    assign load_ready     = (state_q == EMPTY);
    assign refreshcounter = refresh_q;
    assign frame_tick     = frame_tick_q;
    assign digit_nibble   = active_data_q[{refresh_q, 2'b00} +: NIBBLE_W];
    assign digit_dp       = active_dp_q[refresh_q];
    assign digit_blank    = BLANK_LZ ? leading_zero_blank(active_data_q, active_dp_q, refresh_q)
                                     : 1'b0;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed testbench for sseg_scan_ctrl with a 4-cycle slot (16-cycle frame).
// cycleCount counts rising edges since the last reset edge; with a 4-cycle slot
// the active digit is (cycleCount/4)%4 and frames start when cycleCount%16==0.
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [1:0]  refreshcounter;
    logic [3:0]  digit_nibble;
    logic        digit_dp;
    logic        digit_blank;
    logic        frame_tick;

    int checks = 0;
    int failures = 0;
    int cycleCount = 0;

    logic [15:0] curData = '0;
    logic [3:0]  curDp = '0;
    logic [9:0]  obs;

    sseg_scan_ctrl #(
        .REFRESH_DIV (4),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .data_in        (data_in),
        .dp_in          (dp_in),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .refreshcounter (refreshcounter),
        .digit_nibble   (digit_nibble),
        .digit_dp       (digit_dp),
        .digit_blank    (digit_blank),
        .frame_tick     (frame_tick)
    );

    always #5 clk = ~clk;

    // Edge counter used as the timing reference for all expectations.
    always @(posedge clk) begin
        if (!reset_n) cycleCount <= 0;
        else          cycleCount <= cycleCount + 1;
    end

    assign obs = {refreshcounter, digit_nibble, digit_dp, digit_blank, frame_tick, load_ready};

    // Expected {index, nibble, dp, blank, frame_tick, load_ready} for a displayed value.
    function automatic logic [9:0] expVec(input logic [15:0] d, input logic [3:0] p,
                                          input logic rdy, input int n);
        int   slot;
        logic blank;
        logic ft;
        slot  = (n / 4) % 4;
        blank = (slot != 0) && ((d >> (4 * slot)) == 16'h0) && ((p >> slot) == 4'h0);
        ft    = (n > 0) && (n % 16 == 0);
        return {2'(slot), d[4*slot +: 4], p[slot], blank, ft, rdy};
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic advanceTo(input int phase);
        int steps;
        steps = (phase - (cycleCount % 16) + 16) % 16;
        if (steps == 0) steps = 16;
        repeat (steps) stepCycle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) begin
            stepCycle();
            checks++;
            if (obs !== 10'b00_0000_0_0_0_1) begin
                failures++;
                $display("[TB] FAIL reset_values got=%b exp=%b", obs, 10'b00_0000_0_0_0_1);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_scan();
        repeat (20) begin
            stepCycle();
            checks++;
            if (obs !== expVec(16'h0, 4'h0, 1'b1, cycleCount)) begin
                failures++;
                $display("[TB] FAIL scan n=%0d got=%b exp=%b", cycleCount, obs,
                         expVec(16'h0, 4'h0, 1'b1, cycleCount));
            end
        end
    endtask

    task automatic test_load(input string name, input logic [15:0] d, input logic [3:0] p,
                             input int loadPhase, input bit intruder);
        advanceTo(loadPhase);
        data_in = d;
        dp_in = p;
        load_valid = 1'b1;
        stepCycle();
        checks++;
        if (obs !== expVec(curData, curDp, 1'b0, cycleCount)) begin
            failures++;
            $display("[TB] FAIL %s capture n=%0d got=%b exp=%b", name, cycleCount, obs,
                     expVec(curData, curDp, 1'b0, cycleCount));
        end
        if (intruder) begin
            data_in = 16'hAAAA;
            dp_in = 4'hF;
        end else begin
            load_valid = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            if (cycleCount % 16 == 0) break;
            if (cycleCount % 16 == 15) load_valid = 1'b0;
            checks++;
            if (obs !== expVec(curData, curDp, 1'b0, cycleCount)) begin
                failures++;
                $display("[TB] FAIL %s hold n=%0d got=%b exp=%b", name, cycleCount, obs,
                         expVec(curData, curDp, 1'b0, cycleCount));
            end
        end
        load_valid = 1'b0;
        curData = d;
        curDp = p;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) stepCycle();
            checks++;
            if (obs !== expVec(curData, curDp, 1'b1, cycleCount)) begin
                failures++;
                $display("[TB] FAIL %s commit n=%0d got=%b exp=%b", name, cycleCount, obs,
                         expVec(curData, curDp, 1'b1, cycleCount));
            end
        end
    endtask

    task automatic test_reset_pending();
        advanceTo(5);
        data_in = 16'h5A5A;
        dp_in = 4'h3;
        load_valid = 1'b1;
        stepCycle();
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_pending ready got=%b exp=0", load_ready);
        end
        reset_n = 1'b0;
        stepCycle();
        checks++;
        if (obs !== 10'b00_0000_0_0_0_1) begin
            failures++;
            $display("[TB] FAIL rst_pending values got=%b exp=%b", obs, 10'b00_0000_0_0_0_1);
        end
        reset_n = 1'b1;
        curData = '0;
        curDp = '0;
        repeat (20) begin
            stepCycle();
            checks++;
            if (obs !== expVec(16'h0, 4'h0, 1'b1, cycleCount)) begin
                failures++;
                $display("[TB] FAIL rst_pending after n=%0d got=%b exp=%b", cycleCount, obs,
                         expVec(16'h0, 4'h0, 1'b1, cycleCount));
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_scan();
        test_load("midframe", 16'h1234, 4'b0100, 5, 1'b0);
        checks++;
        if (curData[3:0] !== 4'h4) begin
            failures++;
            $display("[TB] FAIL midframe slot0 value got=%h exp=4", curData[3:0]);
        end
        test_load("ignore_second", 16'hBEEF, 4'b0001, 3, 1'b1);
        test_load("blank_0007", 16'h0007, 4'b0000, 5, 1'b0);
        test_load("blank_0000", 16'h0000, 4'b0000, 5, 1'b0);
        test_load("boundary", 16'h00C0, 4'b0000, 15, 1'b0);
        test_reset_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
